// File: rtl/rv32_muldiv_wb_ctrl.sv
// Hazard and writeback controller for the multi-cycle mul/div unit in EX.
// Tracks the in-flight rd, raises RAW/structural stalls, kills on WAW, and injects the result into EX/MEM.
module rv32_muldiv_wb_ctrl #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic            id_is_muldiv_i,
    input  logic            ex_issue_i,
    input  logic            ex_valid_i,
    input  logic            ex_reg_write_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            md_done_i,
    input  logic [XLEN-1:0] md_result_i,
    output logic            stall_o,
    output logic            hold_ex_o,
    output logic            inject_valid_o,
    output logic [RA_W-1:0] inject_rd_o,
    output logic [XLEN-1:0] inject_data_o,
    output logic            pending_o,
    output logic [RA_W-1:0] pending_rd_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_INJECT = 2'd3
    } state_t;

    state_t          r_state,  w_state_nxt;
    logic [RA_W-1:0] r_rd_q,   w_rd_nxt;
    logic [XLEN-1:0] r_data_q, w_data_nxt;
    logic            r_killed_q, w_killed_nxt;

    logic w_clear;
    logic w_kill;
    logic w_raw_rs1;
    logic w_raw_rs2;

    // Reset and flush share one path; outputs are forced quiet while either is asserted.
    assign w_clear = flush_i | ~rst_n_i;

    assign w_kill = (r_state == ST_BUSY) & ex_valid_i & ex_reg_write_i &
                    (ex_rd_i == r_rd_q) & ~hold_ex_o;

    assign w_raw_rs1 = ~r_killed_q & id_rs1_used_i & (id_rs1_i == r_rd_q);
    assign w_raw_rs2 = ~r_killed_q & id_rs2_used_i & (id_rs2_i == r_rd_q);

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_nxt     = r_rd_q;
        w_data_nxt   = r_data_q;
        w_killed_nxt = r_killed_q;

        case (r_state)
            ST_IDLE: begin
                if (ex_issue_i) begin
                    w_rd_nxt     = ex_rd_i;
                    w_killed_nxt = (ex_rd_i == '0);
                    w_state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_kill) begin
                    w_killed_nxt = 1'b1;
                end
                if (md_done_i) begin
                    if (r_killed_q | w_kill) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_data_nxt  = md_result_i;
                        w_state_nxt = ST_INJECT;
                    end
                end
            end
            ST_INJECT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        if (w_clear) begin
            w_state_nxt  = ST_IDLE;
            w_rd_nxt     = '0;
            w_data_nxt   = '0;
            w_killed_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_rd_q     <= '0;
            r_data_q   <= '0;
            r_killed_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_q     <= w_rd_nxt;
            r_data_q   <= w_data_nxt;
            r_killed_q <= w_killed_nxt;
        end
    end

    always_comb begin
        stall_o        = 1'b0;
        hold_ex_o      = 1'b0;
        inject_valid_o = 1'b0;
        inject_rd_o    = '0;
        inject_data_o  = '0;
        pending_o      = 1'b0;
        pending_rd_o   = '0;

        if (!w_clear) begin
            if (r_state == ST_INJECT) begin
                stall_o        = 1'b1;
                hold_ex_o      = 1'b1;
                inject_valid_o = 1'b1;
                inject_rd_o    = r_rd_q;
                inject_data_o  = r_data_q;
            end else if (r_state == ST_BUSY) begin
                stall_o = id_is_muldiv_i | w_raw_rs1 | w_raw_rs2;
            end

            pending_o    = (r_state != ST_IDLE) & ~r_killed_q;
            pending_rd_o = pending_o ? r_rd_q : '0;
        end
    end

endmodule

// File: tb/tb_rv32_muldiv_wb_ctrl.sv
// Directed bench for rv32_muldiv_wb_ctrl: injection timing, RAW stalls, WAW kill, x0, flush and reset.
module tb_rv32_muldiv_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used, id_is_muldiv;
    logic        ex_issue, ex_valid, ex_reg_write;
    logic [4:0]  ex_rd;
    logic        md_done;
    logic [31:0] md_result;
    logic        stall, hold_ex, inject_valid, pending;
    logic [4:0]  inject_rd, pending_rd;
    logic [31:0] inject_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rv32_muldiv_wb_ctrl #(.XLEN(32), .RA_W(5)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .flush_i        (flush),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rs1_used_i  (id_rs1_used),
        .id_rs2_used_i  (id_rs2_used),
        .id_is_muldiv_i (id_is_muldiv),
        .ex_issue_i     (ex_issue),
        .ex_valid_i     (ex_valid),
        .ex_reg_write_i (ex_reg_write),
        .ex_rd_i        (ex_rd),
        .md_done_i      (md_done),
        .md_result_i    (md_result),
        .stall_o        (stall),
        .hold_ex_o      (hold_ex),
        .inject_valid_o (inject_valid),
        .inject_rd_o    (inject_rd),
        .inject_data_o  (inject_data),
        .pending_o      (pending),
        .pending_rd_o   (pending_rd)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_is_muldiv = 0; ex_issue = 0; ex_valid = 0; ex_reg_write = 0; ex_rd = 0;
        md_done = 0; md_result = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        ex_issue = 1; ex_valid = 1; ex_reg_write = 0; ex_rd = rd;
        cyc();
        ex_issue = 0; ex_valid = 0; ex_rd = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
        #1;
        tests_run++;
        if ({stall, hold_ex, inject_valid, inject_rd, inject_data, pending, pending_rd} !== 46'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got stall=%b hold=%b inj=%b rd=%0d data=%h pend=%b prd=%0d, want all 0",
                     stall, hold_ex, inject_valid, inject_rd, inject_data, pending, pending_rd);
        end
    endtask

    task automatic test_div_inject();
        int errs = 0;
        issue(5'd5);
        tests_run++;
        if (pending !== 1'b1 || pending_rd !== 5'd5) begin
            tests_failed++;
            $display("FAIL div_pending: got pend=%b prd=%0d, want 1/5", pending, pending_rd);
        end
        for (int i = 0; i < 33; i++) begin
            if (stall !== 1'b0 || hold_ex !== 1'b0 || inject_valid !== 1'b0) errs++;
            cyc();
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL div_busy_quiet: got %0d busy cycles with stall/hold/inject set, want 0", errs);
        end
        md_done = 1; md_result = 32'h0000_0007;
        #1;
        tests_run++;
        if (stall !== 1'b0 || inject_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_done_cycle: got stall=%b inj=%b, want 0/0", stall, inject_valid);
        end
        cyc();
        md_done = 0; md_result = 32'hFFFF_FFFF;
        #1;
        tests_run++;
        if ({stall, hold_ex, inject_valid, inject_rd, inject_data} !== {3'b111, 5'd5, 32'h7}) begin
            tests_failed++;
            $display("FAIL div_inject: got stall=%b hold=%b inj=%b rd=%0d data=%h, want 1 1 1 5 00000007",
                     stall, hold_ex, inject_valid, inject_rd, inject_data);
        end
        cyc();
        tests_run++;
        if ({stall, hold_ex, inject_valid, inject_rd, inject_data, pending, pending_rd} !== 46'd0) begin
            tests_failed++;
            $display("FAIL div_back_idle: got stall=%b hold=%b inj=%b pend=%b, want all 0",
                     stall, hold_ex, inject_valid, pending);
        end
    endtask

    task automatic test_raw_stall();
        int errs = 0;
        issue(5'd5);
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_rs1_used = 1; id_rs2_used = 1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (stall !== 1'b1) errs++;
            cyc();
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL raw_rs1_stall: got %0d busy cycles without stall, want 0", errs);
        end
        id_rs1 = 5'd1; id_rs2 = 5'd5;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_rs2_stall: got stall=%b, want 1", stall);
        end
        id_rs2_used = 0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_unused_rs2: got stall=%b, want 0", stall);
        end
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_rs2_used = 1;
        md_done = 1; md_result = 32'h0000_1234;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_done_stall: got stall=%b, want 1", stall);
        end
        cyc();
        md_done = 0; md_result = 0;
        #1;
        tests_run++;
        if (stall !== 1'b1 || hold_ex !== 1'b1 || inject_data !== 32'h0000_1234 || inject_rd !== 5'd5) begin
            tests_failed++;
            $display("FAIL raw_inject: got stall=%b hold=%b rd=%0d data=%h, want 1 1 5 00001234",
                     stall, hold_ex, inject_rd, inject_data);
        end
        cyc();
        tests_run++;
        if (stall !== 1'b0 || hold_ex !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_release: got stall=%b hold=%b, want 0/0 so ADD enters EX", stall, hold_ex);
        end
        idle_inputs();
    endtask

    task automatic test_waw_kill();
        issue(5'd5);
        ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd6;
        cyc();
        tests_run++;
        if (pending !== 1'b1 || pending_rd !== 5'd5) begin
            tests_failed++;
            $display("FAIL waw_other_rd: got pend=%b prd=%0d, want 1/5", pending, pending_rd);
        end
        ex_rd = 5'd5;
        cyc();
        ex_valid = 0; ex_reg_write = 0; ex_rd = 0;
        id_rs1 = 5'd5; id_rs1_used = 1;
        #1;
        tests_run++;
        if (pending !== 1'b0 || pending_rd !== 5'd0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL waw_killed: got pend=%b prd=%0d stall=%b, want 0 0 0", pending, pending_rd, stall);
        end
        id_is_muldiv = 1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL waw_struct_stall: got stall=%b, want 1 (still busy)", stall);
        end
        id_is_muldiv = 0;
        cyc();
        md_done = 1; md_result = 32'hDEAD_BEEF;
        cyc();
        md_done = 0;
        id_is_muldiv = 1;
        #1;
        tests_run++;
        if (inject_valid !== 1'b0 || hold_ex !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL waw_no_inject: got inj=%b hold=%b stall=%b, want 0 0 0", inject_valid, hold_ex, stall);
        end
        idle_inputs();
    endtask

    task automatic test_kill_same_cycle();
        issue(5'd7);
        cyc();
        ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd7;
        md_done = 1; md_result = 32'h0BAD_F00D;
        cyc();
        idle_inputs();
        id_is_muldiv = 1;
        #1;
        tests_run++;
        if (inject_valid !== 1'b0 || stall !== 1'b0 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_and_done: got inj=%b stall=%b pend=%b, want 0 0 0", inject_valid, stall, pending);
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        issue(5'd0);
        id_rs1 = 5'd0; id_rs1_used = 1; id_rs2 = 5'd0; id_rs2_used = 1;
        #1;
        tests_run++;
        if (stall !== 1'b0 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_no_raw: got stall=%b pend=%b, want 0/0", stall, pending);
        end
        id_is_muldiv = 1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL x0_second_mul: got stall=%b, want 1", stall);
        end
        cyc(); cyc();
        md_done = 1; md_result = 32'h0000_0042;
        cyc();
        md_done = 0;
        #1;
        tests_run++;
        if (inject_valid !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_no_inject: got inj=%b stall=%b, want 0/0", inject_valid, stall);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        issue(5'd3);
        md_done = 1; md_result = 32'hCAFE_0003;
        cyc();
        md_done = 0;
        cyc();
        issue(5'd4);
        tests_run++;
        if (pending !== 1'b1 || pending_rd !== 5'd4) begin
            tests_failed++;
            $display("FAIL b2b_reissue: got pend=%b prd=%0d, want 1/4", pending, pending_rd);
        end
        md_done = 1; md_result = 32'h0000_0044;
        cyc();
        md_done = 0;
        #1;
        tests_run++;
        if (inject_rd !== 5'd4 || inject_data !== 32'h0000_0044) begin
            tests_failed++;
            $display("FAIL b2b_inject: got rd=%0d data=%h, want 4 00000044", inject_rd, inject_data);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_flush_reset();
        for (int k = 0; k < 2; k++) begin
            issue(5'd9);
            cyc();
            if (k == 0) flush = 1; else rst_n = 0;
            md_done = 1; md_result = 32'h1111_2222;
            cyc();
            flush = 0; rst_n = 1; md_done = 0;
            id_is_muldiv = 1; id_rs1 = 5'd9; id_rs1_used = 1;
            #1;
            tests_run++;
            if ({stall, hold_ex, inject_valid, inject_rd, inject_data, pending, pending_rd} !== 46'd0) begin
                tests_failed++;
                $display("FAIL clear_%0d_outputs: got stall=%b hold=%b inj=%b pend=%b prd=%0d, want all 0",
                         k, stall, hold_ex, inject_valid, pending, pending_rd);
            end
            md_done = 1; md_result = 32'h3333_4444;
            cyc();
            md_done = 0;
            #1;
            tests_run++;
            if (inject_valid !== 1'b0 || stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL clear_%0d_late_done: got inj=%b stall=%b, want 0/0", k, inject_valid, stall);
            end
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_div_inject();
        test_raw_stall();
        test_waw_kill();
        test_kill_same_cycle();
        test_x0();
        test_back_to_back();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
